// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed at the start edge and
// committed after a busy countdown. Build with MDU_CANCEL_EN to add the i_cancel flush input.
module mdu_seq #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [4:0]  i_mduOp,
    input  logic [31:0] i_A,
    input  logic [31:0] i_B,
`ifdef MDU_CANCEL_EN
    input  logic        i_cancel,
`endif
    output logic        o_busy,
    output logic [31:0] o_result,
    output logic [31:0] o_HI,
    output logic [31:0] o_LO
);
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [4:0] {
        OP_DEFAULT = 5'd0, OP_MULT = 5'd1, OP_MULTU = 5'd2, OP_DIV  = 5'd3, OP_DIVU = 5'd4,
        OP_MTLO    = 5'd5, OP_MTHI = 5'd6, OP_MFLO  = 5'd7, OP_MFHI = 5'd8
    } mdu_op_e;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;
    state_e           state;
    logic             cancel;

`ifdef MDU_CANCEL_EN
    assign cancel = i_cancel;
`else
    assign cancel = 1'b0;
`endif

    assign state = (cnt_q != '0) ? ST_BUSY : ST_IDLE;

    // Arithmetic datapath, evaluated from the operands present at the start edge.
    logic [63:0] prod_s, prod_u;
    logic        is_sdiv, a_neg, b_neg;
    logic [31:0] num, den, den_safe, uquo, urem, quo, rem;

    assign prod_s   = {{32{i_A[31]}}, i_A} * {{32{i_B[31]}}, i_B};
    assign prod_u   = {32'd0, i_A} * {32'd0, i_B};
    assign is_sdiv  = (i_mduOp == OP_DIV);
    assign a_neg    = is_sdiv & i_A[31];
    assign b_neg    = is_sdiv & i_B[31];
    assign num      = a_neg ? (~i_A + 32'd1) : i_A;
    assign den      = b_neg ? (~i_B + 32'd1) : i_B;
    // A zero divisor is replaced so the divider never sees x; its result is never committed.
    assign den_safe = (den == 32'd0) ? 32'd1 : den;
    assign uquo     = num / den_safe;
    assign urem     = num % den_safe;
    assign quo      = (a_neg ^ b_neg) ? (~uquo + 32'd1) : uquo;
    assign rem      = a_neg ? (~urem + 32'd1) : urem;

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state)
            ST_BUSY: begin
                if (cancel) begin
                    cnt_d     = '0;
                    pend_wr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1) && pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                if (i_start && !cancel) begin
                    case (i_mduOp)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = rem;
                            pend_lo_d = quo;
                            pend_wr_d = (i_B != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                        end
                        OP_MTLO: lo_d = i_A;
                        OP_MTHI: hi_d = i_A;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        o_result = 32'd0;
        if (i_mduOp == OP_MFHI)      o_result = hi_q;
        else if (i_mduOp == OP_MFLO) o_result = lo_q;
    end

    assign o_busy = (state == ST_BUSY);
    assign o_HI   = hi_q;
    assign o_LO   = lo_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed plus random bench for mdu_seq, checked against an arithmetic reference model.
module tb_mdu_seq;
    localparam int MC = 5;
    localparam int DC = 10;
    localparam logic [4:0] DEF = 5'd0, MULT = 5'd1, MULTU = 5'd2, DIV = 5'd3, DIVU = 5'd4,
                           MTLO = 5'd5, MTHI = 5'd6, MFLO = 5'd7, MFHI = 5'd8;

    logic        clk = 1'b0;
    logic        rst, start, cancel;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] result, hi, lo;

    int errors = 0;
    int checks = 0;

    // Reference state: architectural HI/LO, remaining busy cycles, pending result.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_rem;
    bit          m_pw;

    mdu_seq #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_mduOp(op), .i_A(a), .i_B(b),
`ifdef MDU_CANCEL_EN
        .i_cancel(cancel),
`endif
        .o_busy(busy), .o_result(result), .o_HI(hi), .o_LO(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_rem = 0; m_pw = 0;
    endtask

    task automatic model_edge(input bit s, input logic [4:0] o, input logic [31:0] x,
                              input logic [31:0] y, input bit c);
        longint      sa, sb, q, r;
        logic [63:0] p;
        if (m_rem > 0) begin
            if (c) begin
                m_rem = 0; m_pw = 0;
            end else begin
                m_rem--;
                if (m_rem == 0 && m_pw) begin m_hi = m_phi; m_lo = m_plo; end
            end
        end else if (s && !c) begin
            case (o)
                MULT: begin
                    p = longint'($signed(x)) * longint'($signed(y));
                    m_phi = p[63:32]; m_plo = p[31:0]; m_pw = 1; m_rem = MC;
                end
                MULTU: begin
                    p = 64'(x) * 64'(y);
                    m_phi = p[63:32]; m_plo = p[31:0]; m_pw = 1; m_rem = MC;
                end
                DIV, DIVU: begin
                    m_rem = DC;
                    m_pw  = (y != 0);
                    if (y != 0) begin
                        sa = (o == DIV) ? longint'($signed(x)) : longint'({32'd0, x});
                        sb = (o == DIV) ? longint'($signed(y)) : longint'({32'd0, y});
                        q = sa / sb; r = sa % sb;
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                end
                MTLO: m_lo = x;
                MTHI: m_hi = x;
                default: ;
            endcase
        end
    endtask

    // One clock: drive at posedge+1, check the combinational read, then check state after the edge.
    task automatic cycle(input bit s, input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit c);
        start = s; op = o; a = x; b = y; cancel = c;
        #1;
        chk("result", result, (o == MFHI) ? m_hi : (o == MFLO) ? m_lo : 32'd0);
        @(posedge clk);
        model_edge(s, o, x, y, c);
        #1;
        chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    endtask

    // Idle until not busy, counting busy cycles; optionally inject a start at busy index inj.
    task automatic drain(input string tag, input int exp_n, input int inj, input logic [4:0] inj_op);
        int n = 0;
        while (busy && n < 50) begin
            if (n == inj) cycle(1, inj_op, 32'd7, 32'd2, 0);
            else          cycle(0, DEF, 32'd0, 32'd0, 0);
            n++;
        end
        chk(tag, n, exp_n);
    endtask

    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
        cycle(1, o, x, y, 0);
        drain({tag, "_len"}, n, -1, DEF);
        chk({tag, "_hi"}, hi, ehi);
        chk({tag, "_lo"}, lo, elo);
    endtask

    initial begin
        rst = 0; start = 0; cancel = 0; op = DEF; a = 0; b = 0;
        model_reset();
        #1 rst = 1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk); @(posedge clk); #1 rst = 0;

        run_op("mult", MULT, 32'hFFFFFFFF, 32'd2, MC, 32'hFFFFFFFF, 32'hFFFFFFFE);
        cycle(1, MFLO, 32'd0, 32'd0, 0);
        chk("mflo_mult", result, 32'hFFFFFFFE);

        cycle(1, MULTU, 32'hFFFFFFFF, 32'd2, 0);
        drain("multu_len", MC, 2, DIV);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        run_op("div", DIV, 32'hFFFFFFF9, 32'd2, DC, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", DIVU, 32'd7, 32'd2, DC, 32'd1, 32'd3);

        cycle(1, MTHI, 32'h12345678, 32'd0, 0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        cycle(1, MTLO, 32'h9ABCDEF0, 32'd0, 0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        cycle(1, MFHI, 32'd0, 32'd0, 0);
        chk("mfhi", result, 32'h12345678);
        cycle(1, MFLO, 32'd0, 32'd0, 0);
        chk("mflo", result, 32'h9ABCDEF0);

        cycle(1, MTHI, 32'hA, 32'd0, 0);
        cycle(1, MTLO, 32'hB, 32'd0, 0);
        run_op("divu0", DIVU, 32'd1234, 32'd0, DC, 32'hA, 32'hB);
        run_op("div0", DIV, 32'hFFFFFF00, 32'd0, DC, 32'hA, 32'hB);
        run_op("divovf", DIV, 32'h80000000, 32'hFFFFFFFF, DC, 32'd0, 32'h80000000);
        cycle(1, 5'd13, 32'hDEAD, 32'd0, 0);
        chk("undef_hi", hi, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ry;
            logic [4:0]  ro;
            bit          rc;
            ro = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 8));
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 9));
                2:       ry = 32'hFFFFFFFF;
                default: ry = $urandom;
            endcase
            rc = 0;
`ifdef MDU_CANCEL_EN
            rc = ($urandom_range(0, 15) == 0);
`endif
            cycle($urandom_range(0, 2) != 0, ro, $urandom, ry, rc);
        end
        drain("rand_drain", m_rem, -1, DEF);

`ifdef MDU_CANCEL_EN
        cycle(1, MTHI, 32'h1111, 32'd0, 0);
        cycle(1, MTLO, 32'h2222, 32'd0, 0);
        cycle(1, MULT, 32'd3, 32'd4, 0);
        cycle(0, DEF, 32'd0, 32'd0, 0);
        cycle(0, DEF, 32'd0, 32'd0, 1);
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", hi, 32'h1111);
        chk("cancel_lo", lo, 32'h2222);
        cycle(1, MTHI, 32'h3333, 32'd0, 1);
        chk("cancel_mthi", hi, 32'h1111);
        cycle(1, DIVU, 32'd9, 32'd3, 1);
        chk("cancel_start", {31'd0, busy}, 32'd0);
        cycle(0, DEF, 32'd0, 32'd0, 1);
        chk("cancel_idle_lo", lo, 32'h2222);
`endif

        cycle(1, MTHI, 32'h55, 32'd0, 0);
        cycle(1, MTLO, 32'h66, 32'd0, 0);
        cycle(1, MULT, 32'd6, 32'd7, 0);
        cycle(0, DEF, 32'd0, 32'd0, 0);
        start = 0; op = DEF;
        #2 rst = 1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        model_reset();
        @(posedge clk); #1 rst = 0;
        for (int i = 0; i < MC + 2; i++) cycle(0, DEF, 32'd0, 32'd0, 0);
        chk("arst_nocommit", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multiply/divide unit for the EX stage. It consumes the start pulse and 5-bit MDU opcode produced by the decoder, together with the forwarded rs/rt operands.
- Owns the HI/LO registers.
- Models the multi-cycle latency of mult/div with a busy counter, which the hazard unit uses to stall subsequent MDU instructions.
- Serves mfhi/mflo reads combinationally.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  MDU instruction present in EX this cycle (md | mt | mf)
- i_mduOp  in  5  opcode: DEFAULT=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTLO=5, MTHI=6, MFLO=7, MFHI=8
- i_A  in  32  operand A (rs, forwarded)
- i_B  in  32  operand B (rt, forwarded)
- o_busy  out  1  long operation in flight
- o_result  out  32  HI when i_mduOp==MFHI, LO when MFLO, else 0
- o_HI  out  32  current HI register (debug/trace)
- o_LO  out  32  current LO register (debug/trace)

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_reset is asynchronous and active-high; it clears HI, LO, the counter, the pending result and the op latch, and forces o_busy=0.
- States:
  - IDLE (counter==0).
  - BUSY (counter!=0).
  - o_busy = (counter!=0), registered-derived. It is never combinational from i_start.
- IDLE, edge with i_start=1 and op MULT/MULTU/DIV/DIVU:
  - Compute the 64-bit result from i_A/i_B at that edge and latch it into pending {hi,lo}.
  - Counter loads MULT_CYCLES or DIV_CYCLES.
- BUSY: counter decrements each edge. On the edge where counter==1, pending is committed to HI/LO and the counter becomes 0.
- Latency: a start sampled at edge t gives o_busy=1 for exactly N cycles (after edges t..t+N-1). The first cycle with o_busy=0 already shows the new o_HI/o_LO.
- Multiply:
  - MULT: signed 32x32 to 64, HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 to 64.
- Divide:
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend (i_A).
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (i_B==0, DIV or DIVU): the busy period still runs for DIV_CYCLES; HI/LO are left unchanged at commit.
- MTHI/MTLO with i_start=1 in IDLE: HI (or LO) <= i_A at that edge, no busy.
- MFHI/MFLO: purely combinational read of the current HI/LO. i_start has no sequential effect.
- i_start=1 while o_busy=1 (hazard-unit violation): ignored. No restart, no mt write, the counter is unaffected. mf reads still return the current (old) HI/LO.
- i_start=1 with DEFAULT or an undefined opcode: no effect.
- i_start=0: no state change besides counter decrement.
- Reset mid-operation: the op is abandoned; HI/LO=0 and the pending result is discarded.
- Commit edge with i_start=1: start is ignored (o_busy is still 1 on that edge). A new op is accepted on the next edge.

Optional Feature:
- Macro MDU_CANCEL_EN.
- When defined:
  - Adds input i_cancel (1 bit, sampled at the rising edge), for exception/flush in a later stage.
  - i_cancel=1 while BUSY clears the counter to 0 and discards pending; HI/LO keep their pre-op values; o_busy=0 the following cycle.
  - i_cancel=1 in the same edge as an accepted start (any op, including MT*) suppresses that op entirely.
  - i_cancel in IDLE without start has no effect.
- When undefined: the port is absent and every accepted op runs to commit.

Test Plan:
- Reset, then i_start MULT, i_A=0xFFFFFFFF, i_B=2 -> o_busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MFLO reads 0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. A DIV start asserted in busy cycle 3 is ignored: the counter is not reloaded and HI/LO end as the MULTU result.
- DIV i_A=0xFFFFFFF9 (-7), i_B=2 -> o_busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- MTHI i_A=0x12345678, then MTLO i_A=0x9ABCDEF0 in consecutive cycles -> o_busy stays 0; MFHI=0x12345678 and MFLO=0x9ABCDEF0 on the next cycles.
- DIVU with i_B=0 after HI=0xA, LO=0xB -> busy for 10 cycles; HI/LO remain 0xA/0xB. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- i_reset asserted asynchronously (mid-cycle) in busy cycle 2 of a MULT -> o_busy, HI and LO drop to 0 immediately, with no commit after reset release. With MDU_CANCEL_EN: i_cancel in busy cycle 2 -> busy clears next cycle and HI/LO keep their prior values.
